// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller and the ALU/EXT/NPC/DM blocks it steers.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
  typedef enum logic [2:0] {C_ALU, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR} iclass_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [4:0] ALU_ADD  = 5'b00011;
  localparam logic [4:0] ALU_SUB  = 5'b00100;
  localparam logic [4:0] ALU_SLT  = 5'b00101;
  localparam logic [4:0] ALU_SLTU = 5'b00110;
  localparam logic [4:0] ALU_OR   = 5'b01101;
  localparam logic [4:0] ALU_AND  = 5'b01110;

  localparam logic [5:0] EXT_NONE  = 6'b000000;
  localparam logic [5:0] EXT_SHAMT = 6'b100000;
  localparam logic [5:0] EXT_I     = 6'b010000;
  localparam logic [5:0] EXT_S     = 6'b001000;
  localparam logic [5:0] EXT_B     = 6'b000100;
  localparam logic [5:0] EXT_U     = 6'b000010;
  localparam logic [5:0] EXT_J     = 6'b000001;

  localparam logic [2:0] NPC_PLUS4  = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_JALR   = 3'b100;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC4 = 2'b10;

  localparam logic [2:0] DM_W  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_HU = 3'b010;
  localparam logic [2:0] DM_B  = 3'b011;
  localparam logic [2:0] DM_BU = 3'b100;

  // funct3 bit 0 inverts the sense; bits 2:1 pick Zero, Lt or Ltu.
  function automatic logic branch_taken(input logic [2:0] f3, input logic zero,
                                        input logic lt, input logic ltu);
    logic cond;
    case (f3[2:1])
      2'b00:   cond = zero;
      2'b10:   cond = lt;
      2'b11:   cond = ltu;
      default: cond = 1'b0;
    endcase
    return cond ^ f3[0];
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: class, ALU/EXT controls, DM access type and legality.
module mc_decode
  import mc_ctrl_pkg::*;
#(
  parameter int FULL_BRANCH = 1,
  parameter int SUBWORD_MEM = 1
) (
  input  logic [6:0] op,
  input  logic [6:0] funct7,
  input  logic [2:0] funct3,
  output logic [2:0] iclass,
  output logic [4:0] alu_op,
  output logic       alu_src,
  output logic [5:0] ext_op,
  output logic [2:0] dm_type,
  output logic       legal
);

  localparam logic SUB_OK = (SUBWORD_MEM != 0);
  localparam logic BR_OK  = (FULL_BRANCH != 0);

  always_comb begin
    iclass  = C_ALU;
    alu_op  = ALU_ADD;
    alu_src = 1'b0;
    ext_op  = EXT_NONE;
    dm_type = DM_W;
    legal   = 1'b0;
    case (op)
      OP_R, OP_I: begin
        alu_src = (op == OP_I);
        ext_op  = (op == OP_I) ? EXT_I : EXT_NONE;
        // funct7 only qualifies register-register forms; 0100000 selects sub.
        if (op == OP_R && funct7 == 7'b0100000) begin
          alu_op = ALU_SUB;
          legal  = (funct3 == 3'b000);
        end else if (op == OP_I || funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  begin alu_op = ALU_ADD;  legal = 1'b1; end
            3'b010:  begin alu_op = ALU_SLT;  legal = 1'b1; end
            3'b011:  begin alu_op = ALU_SLTU; legal = 1'b1; end
            3'b110:  begin alu_op = ALU_OR;   legal = 1'b1; end
            3'b111:  begin alu_op = ALU_AND;  legal = 1'b1; end
            default: legal = 1'b0;
          endcase
        end
      end
      OP_LOAD: begin
        iclass  = C_LOAD;
        alu_src = 1'b1;
        ext_op  = EXT_I;
        case (funct3)
          3'b010:  begin dm_type = DM_W;  legal = 1'b1;   end
          3'b000:  begin dm_type = DM_B;  legal = SUB_OK; end
          3'b001:  begin dm_type = DM_H;  legal = SUB_OK; end
          3'b100:  begin dm_type = DM_BU; legal = SUB_OK; end
          3'b101:  begin dm_type = DM_HU; legal = SUB_OK; end
          default: legal = 1'b0;
        endcase
      end
      OP_STORE: begin
        iclass  = C_STORE;
        alu_src = 1'b1;
        ext_op  = EXT_S;
        case (funct3)
          3'b010:  begin dm_type = DM_W; legal = 1'b1;   end
          3'b000:  begin dm_type = DM_B; legal = SUB_OK; end
          3'b001:  begin dm_type = DM_H; legal = SUB_OK; end
          default: legal = 1'b0;
        endcase
      end
      OP_BRANCH: begin
        iclass = C_BRANCH;
        ext_op = EXT_B;
        case (funct3)
          3'b000:         begin alu_op = ALU_SUB;  legal = 1'b1;  end
          3'b001:         begin alu_op = ALU_SUB;  legal = BR_OK; end
          3'b100, 3'b101: begin alu_op = ALU_SLT;  legal = BR_OK; end
          3'b110, 3'b111: begin alu_op = ALU_SLTU; legal = BR_OK; end
          default:        legal = 1'b0;
        endcase
      end
      OP_JAL: begin
        iclass = C_JAL;
        ext_op = EXT_J;
        legal  = 1'b1;
      end
      OP_JALR: begin
        iclass  = C_JALR;
        alu_src = 1'b1;
        ext_op  = EXT_I;
        legal   = (funct3 == 3'b000);
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB/TRAP with imem/dmem ready handshakes.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int FULL_BRANCH = 1,
  parameter int SUBWORD_MEM = 1,
  parameter int TRAP_STICKY = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [6:0] Op,
  input  logic [6:0] Funct7,
  input  logic [2:0] Funct3,
  input  logic       Zero,
  input  logic       Lt,
  input  logic       Ltu,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       ALUSrc,
  output logic [5:0] EXTOp,
  output logic [4:0] ALUOp,
  output logic [2:0] NPCOp,
  output logic [1:0] WDSel,
  output logic [2:0] DMType,
  output logic       illegal,
  output logic       busy
);

  state_t     state;
  logic [2:0] iclass;
  logic [4:0] dec_alu_op;
  logic       dec_alu_src;
  logic [5:0] dec_ext_op;
  logic [2:0] dec_dm_type;
  logic       dec_legal;

  mc_decode #(.FULL_BRANCH(FULL_BRANCH), .SUBWORD_MEM(SUBWORD_MEM)) u_decode (
    .op      (Op),
    .funct7  (Funct7),
    .funct3  (Funct3),
    .iclass  (iclass),
    .alu_op  (dec_alu_op),
    .alu_src (dec_alu_src),
    .ext_op  (dec_ext_op),
    .dm_type (dec_dm_type),
    .legal   (dec_legal)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:  if (imem_ready) state <= S_DECODE;
        S_DECODE: state <= dec_legal ? S_EXEC : S_TRAP;
        S_EXEC: begin
          if (iclass == C_LOAD || iclass == C_STORE) state <= S_MEM;
          else if (iclass == C_ALU)                  state <= S_WB;
          else                                       state <= S_FETCH;
        end
        S_MEM:    if (dmem_ready) state <= (iclass == C_LOAD) ? S_WB : S_FETCH;
        S_WB:     state <= S_FETCH;
        S_TRAP:   if (TRAP_STICKY == 0) state <= S_FETCH;
        default:  state <= S_FETCH;
      endcase
    end
  end

  // Datapath selects stay valid from DECODE through WB so MEM sees a stable address.
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    ALUSrc   = 1'b0;
    EXTOp    = EXT_NONE;
    ALUOp    = 5'b00000;
    NPCOp    = NPC_PLUS4;
    WDSel    = WD_ALU;
    DMType   = DM_W;
    illegal  = (state == S_TRAP);
    busy     = (state != S_FETCH);
    if (state == S_DECODE || state == S_EXEC || state == S_MEM || state == S_WB) begin
      ALUSrc = dec_alu_src;
      EXTOp  = dec_ext_op;
      ALUOp  = dec_alu_op;
      DMType = dec_dm_type;
    end
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        IRWrite  = imem_ready;
      end
      S_EXEC: begin
        if (iclass == C_BRANCH) begin
          PCWrite = 1'b1;
          NPCOp   = branch_taken(Funct3, Zero, Lt, Ltu) ? NPC_BRANCH : NPC_PLUS4;
        end else if (iclass == C_JAL || iclass == C_JALR) begin
          PCWrite  = 1'b1;
          RegWrite = 1'b1;
          WDSel    = WD_PC4;
          NPCOp    = (iclass == C_JAL) ? NPC_JUMP : NPC_JALR;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        MemWrite = (iclass == C_STORE);
        PCWrite  = dmem_ready && (iclass == C_STORE);
      end
      S_WB: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        WDSel    = (iclass == C_LOAD) ? WD_MEM : WD_ALU;
      end
      S_TRAP:  PCWrite = (TRAP_STICKY == 0);
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench: a full-featured controller and a reduced one (beq-only, word-only, non-sticky trap) share stimulus.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic       zero, lt, ltu, imem_ready, dmem_ready;

  logic       imem_req, dmem_req, irwrite, pcwrite, regwrite, memwrite, alusrc, illegal, busy;
  logic [5:0] extop;
  logic [4:0] aluop;
  logic [2:0] npcop, dmtype;
  logic [1:0] wdsel;

  logic       imem_req_b, dmem_req_b, irwrite_b, pcwrite_b, regwrite_b, memwrite_b, alusrc_b;
  logic       illegal_b, busy_b;
  logic [5:0] extop_b;
  logic [4:0] aluop_b;
  logic [2:0] npcop_b, dmtype_b;
  logic [1:0] wdsel_b;

  int checks   = 0;
  int failures = 0;
  logic rw_seen;

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk(clk), .rstn(rstn), .Op(op), .Funct7(f7), .Funct3(f3),
    .Zero(zero), .Lt(lt), .Ltu(ltu), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .IRWrite(irwrite), .PCWrite(pcwrite),
    .RegWrite(regwrite), .MemWrite(memwrite), .ALUSrc(alusrc), .EXTOp(extop),
    .ALUOp(aluop), .NPCOp(npcop), .WDSel(wdsel), .DMType(dmtype),
    .illegal(illegal), .busy(busy)
  );

  mc_ctrl #(.FULL_BRANCH(0), .SUBWORD_MEM(0), .TRAP_STICKY(0)) dut_b (
    .clk(clk), .rstn(rstn), .Op(op), .Funct7(f7), .Funct3(f3),
    .Zero(zero), .Lt(lt), .Ltu(ltu), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req_b), .dmem_req(dmem_req_b), .IRWrite(irwrite_b), .PCWrite(pcwrite_b),
    .RegWrite(regwrite_b), .MemWrite(memwrite_b), .ALUSrc(alusrc_b), .EXTOp(extop_b),
    .ALUOp(aluop_b), .NPCOp(npcop_b), .WDSel(wdsel_b), .DMType(dmtype_b),
    .illegal(illegal_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic set_ir(input logic [6:0] o, input logic [2:0] fn3, input logic [6:0] fn7);
    op = o;
    f3 = fn3;
    f7 = fn7;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    set_ir(7'b0110011, 3'b000, 7'b0000000);
    {zero, lt, ltu, imem_ready, dmem_ready} = '0;

    // Reset state, and FETCH holds while imem_ready is low.
    do_reset();
    chk("rst_imem_req", imem_req, 1);
    chk("rst_busy", busy, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_strobes", {irwrite, pcwrite, regwrite, dmem_req, memwrite}, 0);
    chk("rst_busy_b", busy_b, 0);
    tick();
    chk("fetch_hold_busy", busy, 0);
    chk("fetch_hold_req", imem_req, 1);

    // add: 4 cycles.
    imem_ready = 1'b1;
    #1;
    chk("add_irwrite", irwrite, 1);
    tick();
    chk("add_dec_busy", busy, 1);
    chk("add_dec_irwrite", irwrite, 0);
    chk("add_dec_imem_req", imem_req, 0);
    tick();
    chk("add_ex_aluop", aluop, 5'b00011);
    chk("add_ex_alusrc", alusrc, 0);
    chk("add_ex_wr", {regwrite, pcwrite}, 0);
    tick();
    chk("add_wb_regwrite", regwrite, 1);
    chk("add_wb_wdsel", wdsel, 2'b00);
    chk("add_wb_pcwrite", pcwrite, 1);
    chk("add_wb_npcop", npcop, 3'b000);
    tick();
    chk("add_back_fetch", busy, 0);

    // lw with three wait cycles in MEM.
    set_ir(7'b0000011, 3'b010, 7'b0000000);
    dmem_ready = 1'b0;
    do_reset();
    tick();
    tick();
    chk("lw_ex_aluop", aluop, 5'b00011);
    chk("lw_ex_alusrc", alusrc, 1);
    chk("lw_ex_extop", extop, 6'b010000);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("lw_mem_dmem_req", dmem_req, 1);
      chk("lw_mem_memwrite", memwrite, 0);
      chk("lw_mem_dmtype", dmtype, 3'b000);
      chk("lw_mem_pcwrite", pcwrite, 0);
      if (i == 3) dmem_ready = 1'b1;
      tick();
    end
    dmem_ready = 1'b0;
    chk("lw_wb_dmem_req", dmem_req, 0);
    chk("lw_wb_regwrite", regwrite, 1);
    chk("lw_wb_wdsel", wdsel, 2'b01);
    chk("lw_wb_pcwrite", pcwrite, 1);
    chk("lw_wb_regwrite_b", regwrite_b, 1);

    // sb: legal store on the full build, illegal on the reduced one.
    set_ir(7'b0100011, 3'b000, 7'b0000000);
    dmem_ready = 1'b1;
    do_reset();
    rw_seen = regwrite;
    tick();
    rw_seen |= regwrite;
    tick();
    rw_seen |= regwrite;
    chk("sb_ex_extop", extop, 6'b001000);
    chk("sb_ex_illegal", illegal, 0);
    chk("sb_b_illegal", illegal_b, 1);
    chk("sb_b_trap_pc", {pcwrite_b, npcop_b}, 4'b1000);
    tick();
    rw_seen |= regwrite;
    chk("sb_mem_memwrite", memwrite, 1);
    chk("sb_mem_dmem_req", dmem_req, 1);
    chk("sb_mem_dmtype", dmtype, 3'b011);
    chk("sb_mem_pc", {pcwrite, npcop}, 4'b1000);
    chk("sb_b_after_trap_busy", busy_b, 0);
    chk("sb_b_after_trap_illegal", illegal_b, 0);
    tick();
    rw_seen |= regwrite;
    chk("sb_back_fetch", busy, 0);
    chk("sb_never_regwrite", rw_seen, 0);
    dmem_ready = 1'b0;

    // blt taken then not taken.
    set_ir(7'b1100011, 3'b100, 7'b0000000);
    for (int run = 0; run < 2; run++) begin
      lt = (run == 0);
      do_reset();
      tick();
      tick();
      chk("blt_ex_pcwrite", pcwrite, 1);
      chk("blt_ex_npcop", npcop, (run == 0) ? 3'b001 : 3'b000);
      chk("blt_ex_aluop", aluop, 5'b00101);
      chk("blt_ex_extop", extop, 6'b000100);
      chk("blt_ex_regwrite", regwrite, 0);
      chk("blt_b_trap", illegal_b, 1);
      tick();
      chk("blt_back_fetch", busy, 0);
    end
    lt = 1'b0;

    // beq taken is legal on both builds.
    set_ir(7'b1100011, 3'b000, 7'b0000000);
    zero = 1'b1;
    do_reset();
    tick();
    tick();
    chk("beq_npcop", npcop, 3'b001);
    chk("beq_b_npcop", npcop_b, 3'b001);
    chk("beq_b_illegal", illegal_b, 0);
    chk("beq_b_aluop", aluop_b, 5'b00100);
    zero = 1'b0;

    // jal: link and jump from EXEC.
    set_ir(7'b1101111, 3'b000, 7'b0000000);
    do_reset();
    tick();
    tick();
    chk("jal_ex_ctrl", {regwrite, wdsel, pcwrite, npcop}, {1'b1, 2'b10, 1'b1, 3'b010});
    tick();
    chk("jal_back_fetch", busy, 0);

    // Sticky trap on unknown opcode, cleared only by reset.
    set_ir(7'b1111111, 3'b000, 7'b0000000);
    do_reset();
    tick();
    tick();
    chk("trap_b_pc", {pcwrite_b, npcop_b}, 4'b1000);
    for (int i = 0; i < 20; i++) begin
      chk("trap_illegal", illegal, 1);
      chk("trap_imem_req", imem_req, 0);
      if (i == 1) chk("trap_b_refetch", {illegal_b, imem_req_b}, 2'b01);
      tick();
    end
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("trap_rst_imem_req", imem_req, 1);
    chk("trap_rst_illegal", illegal, 0);
    chk("trap_rst_busy", busy, 0);

    // Reset while a store is stalled in MEM.
    set_ir(7'b0100011, 3'b010, 7'b0000000);
    dmem_ready = 1'b0;
    do_reset();
    tick();
    tick();
    tick();
    chk("rstmem_pre_req", {dmem_req, memwrite}, 2'b11);
    rstn = 1'b0;
    tick();
    chk("rstmem_dmem_req", dmem_req, 0);
    chk("rstmem_strobes", {memwrite, regwrite, pcwrite}, 0);
    chk("rstmem_busy", busy, 0);
    chk("rstmem_imem_req", imem_req, 1);
    rstn = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
